// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
//
// Multi-read-port register file with a per-register busy scoreboard.
//   - Clocked synchronous write, one-cycle latency into the array.
//   - Combinational reads with write-through bypass of the in-flight write.
//   - Busy bits are set by reservations (issue) and cleared by writebacks,
//     letting issue logic detect RAW hazards on pending producers.
//   - Optional hardwired register 0 (ZERO_REG=1).
//
// Parameters
//   DATA_W    register width in bits
//   DEPTH     number of registers (need not be a power of two)
//   ADDR_W    address width, 2**ADDR_W >= DEPTH
//   NUM_RD    number of independent read ports
//   ZERO_REG  1: register 0 reads 0, ignores writes/reserves, never busy
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   wr_en     writeback strobe
//   wr_addr   writeback address
//   wr_data   writeback data
//   rsv_en    reserve strobe, marks rsv_addr busy
//   rsv_addr  register to reserve
//   rd_addr   packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data   packed read data,      port k = [k*DATA_W +: DATA_W]
//   rd_busy   busy flag per read port
//   addr_err  sticky flag: out-of-range write or reserve seen since reset
// ----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     addr_err
);

    // DEPTH expressed at ADDR_W+1 bits so the range compare has matching
    // widths and still works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              addr_err_q;
    logic              addr_err_d;

    // ------------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------------
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_CMP;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    logic wr_in_range;
    logic rsv_in_range;
    logic wr_ok;
    logic rsv_ok;

    always_comb begin
        wr_in_range  = in_range(wr_addr);
        rsv_in_range = in_range(rsv_addr);
        // Writes/reserves to a hardwired R0 are dropped without flagging.
        wr_ok        = wr_en  && wr_in_range  && !is_zero_reg(wr_addr);
        rsv_ok       = rsv_en && rsv_in_range && !is_zero_reg(rsv_addr);
    end

    // ------------------------------------------------------------------------
    // Scoreboard and error next-state
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        // Writeback clears first so a same-cycle reservation of the same
        // register (a newer producer) leaves it busy.
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        addr_err_d = addr_err_q;
        if ((wr_en && !wr_in_range) || (rsv_en && !rsv_in_range)) begin
            addr_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            logic [ADDR_W-1:0] ra;
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (in_range(ra) && !is_zero_reg(ra)) begin
                if (!rst && wr_en && (wr_addr == ra)) begin
                    // Bypass: the write lands this edge and clears busy.
                    rd_data[k*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
                    rd_busy[k]                  = !rst && busy_q[ra];
                end
            end
        end
    end

    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Two instances share write/reserve stimulus:
//   dut_a: DEPTH=32, ZERO_REG=0, NUM_RD=2
//   dut_b: DEPTH=24, ZERO_REG=1, NUM_RD=3 (exercises range errors and R0)
// A behavioural model (plain arrays) predicts every read port and addr_err.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [14:0] rd_addr_b;
    logic [9:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic        err_a;
    logic [47:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic        err_b;

    assign rd_addr_a = rd_addr_b[9:0];

    reg_file_sb #(
        .DATA_W(16), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a),
        .addr_err (err_a)
    );

    reg_file_sb #(
        .DATA_W(16), .DEPTH(24), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1'b1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .addr_err (err_b)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [15:0] m_reg  [2][32];
    logic        m_busy [2][32];
    logic        m_err  [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int depth_of(input int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic bit zr_of(input int i);
        return i == 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply the effect of one clock edge to the model.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_reg[i][r]  = '0;
                    m_busy[i][r] = 1'b0;
                end
                m_err[i] = 1'b0;
            end else begin
                if (wr_en) begin
                    if (int'(wr_addr) >= depth_of(i)) m_err[i] = 1'b1;
                    else if (!(zr_of(i) && wr_addr == 0)) begin
                        m_reg[i][wr_addr]  = wr_data;
                        m_busy[i][wr_addr] = 1'b0;
                    end
                end
                if (rsv_en) begin
                    if (int'(rsv_addr) >= depth_of(i)) m_err[i] = 1'b1;
                    else if (!(zr_of(i) && rsv_addr == 0)) m_busy[i][rsv_addr] = 1'b1;
                end
            end
        end
    endtask

    task automatic exp_read(input int i, input int a, output logic [15:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (a >= depth_of(i)) return;
        if (zr_of(i) && a == 0) return;
        if (wr_en && int'(wr_addr) == a) begin
            d = wr_data;
            return;
        end
        d = m_reg[i][a];
        b = m_busy[i][a];
    endtask

    task automatic check_all();
        logic [15:0] d;
        logic        b;
        int          a;
        for (int k = 0; k < 2; k++) begin
            a = int'(rd_addr_b[k*5 +: 5]);
            exp_read(0, a, d, b);
            check_eq($sformatf("a_data%0d@%0d", k, a), 32'(rd_data_a[k*16 +: 16]), 32'(d));
            check_eq($sformatf("a_busy%0d@%0d", k, a), 32'(rd_busy_a[k]), 32'(b));
        end
        for (int k = 0; k < 3; k++) begin
            a = int'(rd_addr_b[k*5 +: 5]);
            exp_read(1, a, d, b);
            check_eq($sformatf("b_data%0d@%0d", k, a), 32'(rd_data_b[k*16 +: 16]), 32'(d));
            check_eq($sformatf("b_busy%0d@%0d", k, a), 32'(rd_busy_b[k]), 32'(b));
        end
        check_eq("a_err", 32'(err_a), 32'(m_err[0]));
        check_eq("b_err", 32'(err_b), 32'(m_err[1]));
    endtask

    // Inputs are set just after a rising edge; outputs sampled on the
    // falling edge, then the model advances at the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr_b = {5'(a2), 5'(a1), 5'(a0)};
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0; rd_addr_b = '0;
        @(posedge clk); model_edge(); #1;
        tick();
        rst = 1'b0;
        tick();

        // T1: state then reset clears everything
        wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; tick();
        idle(); rsv_en = 1; rsv_addr = 7; tick();
        idle(); rst = 1; tick();
        rst = 0; set_rd(5, 7, 5); #2;
        check_eq("t1_a_d0", 32'(rd_data_a[15:0]), 32'h0);
        check_eq("t1_a_busy", 32'(rd_busy_a), 32'h0);
        check_eq("t1_b_busy", 32'(rd_busy_b), 32'h0);
        check_eq("t1_err", 32'({err_a, err_b}), 32'h0);
        tick();

        // T2: bypass, then stored value
        wr_en = 1; wr_addr = 3; wr_data = 16'h1234; set_rd(3, 3, 3); #2;
        check_eq("t2_bypass", 32'(rd_data_a[15:0]), 32'h1234);
        tick();
        idle(); #2;
        check_eq("t2_stored", 32'(rd_data_a[15:0]), 32'h1234);
        tick();

        // T3: reserve then writeback clears busy combinationally
        rsv_en = 1; rsv_addr = 9; tick();
        idle(); set_rd(9, 9, 9); #2;
        check_eq("t3_busy_a", 32'(rd_busy_a), 32'h3);
        check_eq("t3_busy_b", 32'(rd_busy_b), 32'h7);
        wr_en = 1; wr_addr = 9; wr_data = 16'h00AA; #1;
        check_eq("t3_clr_busy", 32'(rd_busy_a), 32'h0);
        check_eq("t3_clr_data", 32'(rd_data_a[31:16]), 32'h00AA);
        tick();

        // T4: simultaneous write and reserve on R4
        idle(); wr_en = 1; rsv_en = 1; wr_addr = 4; rsv_addr = 4; wr_data = 16'h5555;
        tick();
        idle(); set_rd(4, 4, 4); #2;
        check_eq("t4_data", 32'(rd_data_a[15:0]), 32'h5555);
        check_eq("t4_busy", 32'(rd_busy_a[0]), 32'h1);
        tick();

        // T5: R0 writes/reserves dropped on the ZERO_REG instance
        wr_en = 1; rsv_en = 1; wr_addr = 0; rsv_addr = 0; wr_data = 16'hFFFF;
        tick();
        idle(); set_rd(0, 0, 0); #2;
        check_eq("t5_b_data", 32'(rd_data_b[15:0]), 32'h0);
        check_eq("t5_b_busy", 32'(rd_busy_b), 32'h0);
        check_eq("t5_b_err", 32'(err_b), 32'h0);
        check_eq("t5_a_data", 32'(rd_data_a[15:0]), 32'hFFFF);
        tick();

        // T6: out-of-range write on the DEPTH=24 instance
        wr_en = 1; wr_addr = 30; wr_data = 16'h7777; tick();
        idle(); set_rd(30, 30, 30); #2;
        check_eq("t6_err_b", 32'(err_b), 32'h1);
        check_eq("t6_err_a", 32'(err_a), 32'h0);
        check_eq("t6_rd30_b", 32'(rd_data_b[15:0]), 32'h0);
        tick();
        for (int a = 0; a < 24; a++) begin
            set_rd(a, 23 - a, a);
            tick();
        end
        #2 check_eq("t6_sticky", 32'(err_b), 32'h1);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            rsv_en   = $urandom_range(0, 9) < 4;
            wr_addr  = 5'($urandom_range(0, 31));
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            wr_data  = 16'($urandom);
            for (int k = 0; k < 3; k++) begin
                rd_addr_b[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr
                                                                 : 5'($urandom_range(0, 31));
            end
            tick();
        end
        rst = 0; idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
